// File: rtl/alu_pkg.sv
// Shared ALU op codes and arbiter FSM state encoding.
package alu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;
    localparam logic [2:0] ALU_NOR = 3'b100;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RESP = 1'b1;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: AND/OR/ADD/SUB/SLT/NOR with zero, signed-overflow and illegal-op flags.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             ovf,
    output logic             ill
);

    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;

    // SUB shares the adder as a + ~b + 1
    assign is_sub = (op == ALU_SUB);
    assign b_eff  = is_sub ? ~b : b;
    assign sum    = a + b_eff + WIDTH'(is_sub);

    always_comb begin
        y   = '0;
        ovf = 1'b0;
        ill = 1'b0;
        case (op)
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_NOR: y = ~(a | b);
            ALU_ADD, ALU_SUB: begin
                y   = sum;
                ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SLT: y = WIDTH'($signed(a) < $signed(b));
            default: ill = 1'b1;
        endcase
    end

    assign zero = (y == '0);

endmodule

// File: rtl/alu_share_arb.sv
// Round-robin arbiter sharing one ALU between two requesters, with held responses and an op counter.
module alu_share_arb
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid_0,
    output logic             req_ready_0,
    input  logic [2:0]       req_op_0,
    input  logic [WIDTH-1:0] req_a_0,
    input  logic [WIDTH-1:0] req_b_0,
    output logic             resp_valid_0,
    input  logic             resp_ready_0,
    input  logic             req_valid_1,
    output logic             req_ready_1,
    input  logic [2:0]       req_op_1,
    input  logic [WIDTH-1:0] req_a_1,
    input  logic [WIDTH-1:0] req_b_1,
    output logic             resp_valid_1,
    input  logic             resp_ready_1,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_zero,
    output logic             resp_ovf,
    output logic             resp_ill,
    output logic [CNT_W-1:0] op_count
);

    logic [0:0]       state;
    logic [0:0]       state_nxt;
    logic             owner;
    logic             last_grant;
    logic             grant_c;
    logic             accept_c;
    logic             done_c;
    logic [2:0]       sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [WIDTH-1:0] alu_y;
    logic             alu_zero;
    logic             alu_ovf;
    logic             alu_ill;

    // On a tie the requester that did not win last time gets the ALU
    always_comb begin
        grant_c = 1'b0;
        if (req_valid_0 && req_valid_1) begin
            grant_c = ~last_grant;
        end else if (req_valid_1) begin
            grant_c = 1'b1;
        end
    end

    assign req_ready_0 = (state == ST_IDLE) && req_valid_0 && !grant_c;
    assign req_ready_1 = (state == ST_IDLE) && req_valid_1 && grant_c;
    assign accept_c    = req_ready_0 || req_ready_1;
    assign done_c      = (state == ST_RESP) && (owner ? resp_ready_1 : resp_ready_0);

    assign sel_op = grant_c ? req_op_1 : req_op_0;
    assign sel_a  = grant_c ? req_a_1  : req_a_0;
    assign sel_b  = grant_c ? req_b_1  : req_b_0;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_alu_core (
        .op   (sel_op),
        .a    (sel_a),
        .b    (sel_b),
        .y    (alu_y),
        .zero (alu_zero),
        .ovf  (alu_ovf),
        .ill  (alu_ill)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept_c) state_nxt = ST_RESP;
            ST_RESP: if (done_c)   state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Result registers, ownership and completion counter
    always_ff @(posedge clk) begin
        if (rst) begin
            owner        <= 1'b0;
            last_grant   <= 1'b1;
            resp_valid_0 <= 1'b0;
            resp_valid_1 <= 1'b0;
            resp_data    <= '0;
            resp_zero    <= 1'b0;
            resp_ovf     <= 1'b0;
            resp_ill     <= 1'b0;
            op_count     <= '0;
        end else if (accept_c) begin
            owner        <= grant_c;
            last_grant   <= grant_c;
            resp_valid_0 <= !grant_c;
            resp_valid_1 <= grant_c;
            resp_data    <= alu_y;
            resp_zero    <= alu_zero;
            resp_ovf     <= alu_ovf;
            resp_ill     <= alu_ill;
        end else if (done_c) begin
            resp_valid_0 <= 1'b0;
            resp_valid_1 <= 1'b0;
            op_count     <= op_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed + randomized bench for alu_share_arb against a transaction-level reference model.
module tb_alu_share_arb;

    logic        clk;
    logic        rst;
    logic        req_valid_0, req_valid_1;
    logic        req_ready_0, req_ready_1;
    logic [2:0]  req_op_0, req_op_1;
    logic [31:0] req_a_0, req_b_0, req_a_1, req_b_1;
    logic        resp_valid_0, resp_valid_1;
    logic        resp_ready_0, resp_ready_1;
    logic [31:0] resp_data;
    logic        resp_zero, resp_ovf, resp_ill;
    logic [15:0] op_count;
    logic        s_req_ready_0, s_req_ready_1, s_resp_valid_0, s_resp_valid_1;
    logic [31:0] s_resp_data;
    logic        s_resp_zero, s_resp_ovf, s_resp_ill;
    logic [1:0]  s_op_count;

    int vectors = 0;
    int miscompares = 0;

    // model state
    bit          m_held, m_owner, m_last;
    logic [31:0] m_data;
    bit          m_zero, m_ovf, m_ill;
    int          m_count;
    bit          acc0, acc1;

    alu_share_arb #(.WIDTH(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid_0(req_valid_0), .req_ready_0(req_ready_0), .req_op_0(req_op_0),
        .req_a_0(req_a_0), .req_b_0(req_b_0), .resp_valid_0(resp_valid_0), .resp_ready_0(resp_ready_0),
        .req_valid_1(req_valid_1), .req_ready_1(req_ready_1), .req_op_1(req_op_1),
        .req_a_1(req_a_1), .req_b_1(req_b_1), .resp_valid_1(resp_valid_1), .resp_ready_1(resp_ready_1),
        .resp_data(resp_data), .resp_zero(resp_zero), .resp_ovf(resp_ovf), .resp_ill(resp_ill),
        .op_count(op_count)
    );

    // narrow-counter instance shares the stimulus to exercise counter wrap
    alu_share_arb #(.WIDTH(32), .CNT_W(2)) dut_small (
        .clk(clk), .rst(rst),
        .req_valid_0(req_valid_0), .req_ready_0(s_req_ready_0), .req_op_0(req_op_0),
        .req_a_0(req_a_0), .req_b_0(req_b_0), .resp_valid_0(s_resp_valid_0), .resp_ready_0(resp_ready_0),
        .req_valid_1(req_valid_1), .req_ready_1(s_req_ready_1), .req_op_1(req_op_1),
        .req_a_1(req_a_1), .req_b_1(req_b_1), .resp_valid_1(s_resp_valid_1), .resp_ready_1(resp_ready_1),
        .resp_data(s_resp_data), .resp_zero(s_resp_zero), .resp_ovf(s_resp_ovf), .resp_ill(s_resp_ill),
        .op_count(s_op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ALU semantics from signed/unsigned arithmetic on wide integers
    task automatic alu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] y, output bit ov, output bit il);
        longint sa, sb, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        y = 32'd0; ov = 1'b0; il = 1'b0; r = 0;
        case (op)
            3'b000: y = a & b;
            3'b001: y = a | b;
            3'b100: y = ~(a | b);
            3'b010: begin r = sa + sb; y = r[31:0]; ov = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
            3'b110: begin r = sa - sb; y = r[31:0]; ov = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
            3'b111: y = (sa < sb) ? 32'd1 : 32'd0;
            default: il = 1'b1;
        endcase
    endtask

    task automatic model_reset();
        m_held = 0; m_owner = 0; m_last = 1; m_data = 32'd0;
        m_zero = 0; m_ovf = 0; m_ill = 0; m_count = 0;
    endtask

    // Compare all outputs with the model, then advance one clock and the model with it
    task automatic cycle();
        bit g, er0, er1, ov, il;
        logic [31:0] y;
        #1;
        g   = (req_valid_0 && req_valid_1) ? !m_last : req_valid_1;
        er0 = !m_held && req_valid_0 && !g;
        er1 = !m_held && req_valid_1 && g;
        if (req_valid_0 || req_valid_1) begin
            check("req_ready_0", 64'(req_ready_0), 64'(er0));
            check("req_ready_1", 64'(req_ready_1), 64'(er1));
            check("small_req_ready_0", 64'(s_req_ready_0), 64'(er0));
        end
        check("resp_valid_0", 64'(resp_valid_0), 64'(m_held && !m_owner));
        check("resp_valid_1", 64'(resp_valid_1), 64'(m_held && m_owner));
        check("resp_data", 64'(resp_data), 64'(m_data));
        check("resp_zero", 64'(resp_zero), 64'(m_zero));
        check("resp_ovf", 64'(resp_ovf), 64'(m_ovf));
        check("resp_ill", 64'(resp_ill), 64'(m_ill));
        check("op_count", 64'(op_count), 64'(m_count % 65536));
        check("small_op_count", 64'(s_op_count), 64'(m_count % 4));
        acc0 = er0 && !rst;
        acc1 = er1 && !rst;
        if (rst) begin
            model_reset();
        end else if (!m_held) begin
            if (er0 || er1) begin
                if (g) alu_ref(req_op_1, req_a_1, req_b_1, y, ov, il);
                else   alu_ref(req_op_0, req_a_0, req_b_0, y, ov, il);
                m_data = y; m_zero = (y == 32'd0); m_ovf = ov; m_ill = il;
                m_held = 1; m_owner = g; m_last = g;
            end
        end else if (m_owner ? resp_ready_1 : resp_ready_0) begin
            m_held = 0;
            m_count++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;
    endtask

    task automatic single(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ed, input bit eo, input bit ei);
        req_valid_0 = 1'b1; req_op_0 = op; req_a_0 = a; req_b_0 = b; resp_ready_0 = 1'b0;
        cycle();
        req_valid_0 = 1'b0;
        check("single_data", 64'(resp_data), 64'(ed));
        check("single_ovf", 64'(resp_ovf), 64'(eo));
        check("single_ill", 64'(resp_ill), 64'(ei));
        resp_ready_0 = 1'b1;
        cycle();
        resp_ready_0 = 1'b0;
    endtask

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            4: return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        req_valid_0 = 0; req_valid_1 = 0; resp_ready_0 = 0; resp_ready_1 = 0;
        req_op_0 = 0; req_op_1 = 0; req_a_0 = 0; req_b_0 = 0; req_a_1 = 0; req_b_1 = 0;
        rst = 1'b1;
        model_reset();
        reset_dut();

        // basic ADD 5+7
        req_valid_0 = 1; req_op_0 = 3'b010; req_a_0 = 32'd5; req_b_0 = 32'd7;
        cycle();
        req_valid_0 = 0;
        check("add_valid", 64'(resp_valid_0), 64'd1);
        check("add_data", 64'(resp_data), 64'd12);
        check("add_zero", 64'(resp_zero), 64'd0);
        resp_ready_0 = 1;
        cycle();
        resp_ready_0 = 0;
        check("add_count", 64'(op_count), 64'd1);

        // tie alternation with continuous requests
        reset_dut();
        req_valid_0 = 1; req_op_0 = 3'b000; req_a_0 = 32'hF0F0_F0F0; req_b_0 = 32'h0FF0_0FF0;
        req_valid_1 = 1; req_op_1 = 3'b110; req_a_1 = 32'd3; req_b_1 = 32'd3;
        resp_ready_0 = 1; resp_ready_1 = 1;
        cycle();
        check("rr_first_owner0", 64'(resp_valid_0), 64'd1);
        check("rr_and_data", 64'(resp_data), 64'h00F0_00F0);
        cycle();
        cycle();
        check("rr_second_owner1", 64'(resp_valid_1), 64'd1);
        check("rr_sub_zero", 64'(resp_zero), 64'd1);
        for (int i = 0; i < 6; i++) cycle();
        req_valid_0 = 0; req_valid_1 = 0;
        cycle();
        resp_ready_0 = 0; resp_ready_1 = 0;
        cycle();

        // arithmetic corners and illegal ops
        single(3'b010, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b1, 1'b0);
        single(3'b110, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b1, 1'b0);
        single(3'b111, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0);
        single(3'b011, 32'h1234_5678, 32'd9, 32'd0, 1'b0, 1'b1);
        single(3'b101, 32'hFFFF_FFFF, 32'd9, 32'd0, 1'b0, 1'b1);

        // backpressure on requester 1 while requester 0 waits
        req_valid_1 = 1; req_op_1 = 3'b010; req_a_1 = 32'd10; req_b_1 = 32'd20;
        cycle();
        req_valid_1 = 0;
        req_valid_0 = 1; req_op_0 = 3'b001; req_a_0 = 32'h0000_FF00; req_b_0 = 32'h00FF_0000;
        for (int i = 0; i < 5; i++) begin
            resp_ready_0 = i[0];
            cycle();
            check("bp_ready0_low", 64'(req_ready_0), 64'd0);
            check("bp_data_stable", 64'(resp_data), 64'd30);
        end
        resp_ready_0 = 0; resp_ready_1 = 1;
        cycle();
        resp_ready_1 = 0;
        cycle();
        req_valid_0 = 0; resp_ready_0 = 1;
        cycle();
        resp_ready_0 = 0;

        // reset while a result is held
        req_valid_0 = 1; req_op_0 = 3'b000; req_a_0 = 32'hFFFF_FFFF; req_b_0 = 32'h5;
        cycle();
        req_valid_0 = 0; resp_ready_0 = 1; rst = 1;
        cycle();
        rst = 0; resp_ready_0 = 0;
        check("rst_valid0", 64'(resp_valid_0), 64'd0);
        check("rst_count", 64'(op_count), 64'd0);
        req_valid_0 = 1; req_op_0 = 3'b100; req_a_0 = 32'h1; req_b_0 = 32'h2;
        req_valid_1 = 1; req_op_1 = 3'b001; req_a_1 = 32'h4; req_b_1 = 32'h8;
        cycle();
        check("rst_tie_owner0", 64'(resp_valid_0), 64'd1);
        req_valid_0 = 0; resp_ready_0 = 1;
        cycle();
        resp_ready_0 = 0;
        cycle();
        req_valid_1 = 0; resp_ready_1 = 1;
        cycle();
        resp_ready_1 = 0;

        // narrow counter wraps after four completions
        reset_dut();
        for (int i = 0; i < 4; i++) single(3'b001, 32'(i), 32'd1, 32'(i) | 32'd1, 1'b0, 1'b0);
        check("wrap_small", 64'(s_op_count), 64'd0);
        check("wrap_wide", 64'(op_count), 64'd4);

        // randomized traffic obeying the hold rule
        for (int n = 0; n < 2000; n++) begin
            if (!req_valid_0 && $urandom_range(0, 2) == 0) begin
                req_valid_0 = 1; req_op_0 = 3'($urandom_range(0, 7));
                req_a_0 = rnd_opnd(); req_b_0 = rnd_opnd();
            end
            if (!req_valid_1 && $urandom_range(0, 2) == 0) begin
                req_valid_1 = 1; req_op_1 = 3'($urandom_range(0, 7));
                req_a_1 = rnd_opnd(); req_b_1 = rnd_opnd();
            end
            resp_ready_0 = ($urandom_range(0, 3) != 0);
            resp_ready_1 = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 199) == 0);
            cycle();
            rst = 0;
            if (acc0) req_valid_0 = 0;
            if (acc1) req_valid_1 = 0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Round-robin arbiter and sequencer that shares one 32-bit ALU between two requesters, e.g. the execute stage and the address/branch unit. Each requester issues an operation over a valid/ready handshake. The block grants one request at a time, computes the result and registers it. It holds the result on a per-requester response handshake until that requester accepts it. The block also keeps a completed-operation counter for performance debug.

## Interface
Parameters:
- WIDTH, default 32: operand and result width.
- CNT_W, default 16: width of the completed-operation counter.

Ports (the suffix i is 0 or 1; there is one full set per requester):
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- req_valid_i, input, 1: requester i presents an operation.
- req_ready_i, output, 1: the block accepts requester i's operation this cycle.
- req_op_i, input, 3: ALU operation code.
- req_a_i, input, WIDTH: operand A.
- req_b_i, input, WIDTH: operand B.
- resp_valid_i, output, 1: a result is pending for requester i.
- resp_ready_i, input, 1: requester i consumes the result.
- resp_data, output, WIDTH: registered result (shared bus).
- resp_zero, output, 1: resp_data == 0.
- resp_ovf, output, 1: signed overflow on ADD/SUB; 0 for other ops.
- resp_ill, output, 1: the op code was illegal.
- op_count, output, CNT_W: number of completed response handshakes, wrapping.

## Operation
- Op codes:
  - 000 AND, 001 OR, 010 ADD, 110 SUB.
  - 111 SLT: signed; result is 1 if A < B, else 0.
  - 100 NOR.
  - Any other code: result 0, resp_ill = 1.
- FSM with two states:
  - IDLE: no result is held.
  - RESP: a result is held for the owner.
- Arbitration in IDLE:
  - Exactly one requester valid: grant it.
  - Both valid: grant the requester that is not last_grant.
  - Grant is combinational from the valids. req_ready_i = (state == IDLE) && grant == i.
  - req_ready_i never depends on resp_ready.
- On accept (req_valid_i && req_ready_i):
  - Register the result and flags.
  - Set owner = i and last_grant = i.
  - Go to RESP.
- In RESP:
  - resp_valid_owner = 1; the other resp_valid = 0.
  - Both req_ready = 0.
  - resp_data and the flags are held stable.
  - On resp_ready_owner: go to IDLE and increment op_count.
  - resp_ready from the non-owner is ignored.
- ADD/SUB arithmetic is modulo 2^WIDTH. ovf = (sign of A matches sign of B' where B' = B for ADD, ~B for SUB) && sign of result differs.
- op_count wraps from 2^CNT_W−1 to 0.

## Timing
- Reset values:
  - state IDLE, last_grant = 1 (requester 0 wins the first tie).
  - owner = 0.
  - resp_valid_0/1 = 0.
  - resp_data = 0, resp_zero = 0, resp_ovf = 0, resp_ill = 0.
  - op_count = 0.
  - req_ready follows the IDLE rule, so it is combinationally valid-driven after reset.
- Latency: accept in cycle N, resp_valid high in cycle N+1.
- Minimum occupancy is 2 cycles per operation: accept in N, response handshake in N+1, IDLE in N+2, next accept in N+2.
- Maximum throughput is one operation per 2 cycles.
- Requester hold rule: a requester must keep req_valid and its fields stable until accepted. The block does not check this.
- Fairness: under continuous requests from both, grants alternate 0,1,0,1. A lone requester is granted back-to-back every 2 cycles.
- Reset in RESP: the held result is dropped and no handshake is counted. The next cycle is IDLE with outputs at their reset values.
- A req_valid asserted in the same cycle as a RESP→IDLE transition is not accepted until the following cycle.

## Structure
- Shared package alu_pkg:
  - op code localparams (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR).
  - FSM state encoding (ST_IDLE, ST_RESP).
- Sub-module alu_core: purely combinational. Inputs op, a, b; outputs y, zero, ovf, ill. It is reusable by the single-cycle datapath.
- The top contains the arbiter, FSM, result registers and counter.

## Test plan
- Reset, then req_valid_0 with op=010, a=5, b=7:
  - req_ready_0 = 1 in cycle 0.
  - Cycle 1: resp_valid_0 = 1, resp_data = 12, zero = 0.
  - resp_ready_0 = 1 gives op_count = 1.
- Both requesters valid and continuously re-issuing (0: AND 0xF0F0F0F0 & 0x0FF00FF0; 1: SUB 3−3), resp_ready tied high:
  - Grant order 0,1,0,1.
  - Results 0x00F000F0, then 0 with zero = 1.
- Overflow cases:
  - ADD 0x7FFFFFFF+1 gives 0x80000000, ovf = 1.
  - SUB 0x80000000−1 gives 0x7FFFFFFF, ovf = 1.
  - SLT −1 vs 1 gives 1.
- Illegal op 011: resp_data = 0, resp_ill = 1.
- Backpressure: hold resp_ready_1 = 0 for 5 cycles while req_valid_0 = 1:
  - req_ready_0 stays 0 and resp_data stays stable.
  - Pulsing resp_ready_0 during this period has no effect.
- Assert rst while in RESP:
  - Next cycle resp_valid = 0, op_count unchanged from its reset value of 0.
  - Requester 0 wins the next tie.
  - op_count wrap is checked with CNT_W = 2: 4 operations give 0.
